// File: rtl/breath_ramp_gen.sv
// Breathing-LED duty ramp: sawtooth or triangle duty sequence, stepped on PWM
// period boundaries so duty changes never tear a PWM period.
module breath_ramp_gen #(
  parameter int unsigned STEP_TICKS = 125000,
  parameter logic [31:0] DUTY_MAX   = 32'd100,
  parameter int unsigned HOLD_STEPS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mode,
  input  logic        period_wrap,
  output logic [31:0] duty_cycle,
  output logic        duty_update,
  output logic [2:0]  state
);

  localparam int PW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(STEP_TICKS - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_STEPS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t          st, st_n;
  logic [PW-1:0]   presc, presc_n;
  logic [HW-1:0]   hold, hold_n;
  logic            pending, pending_n;
  logic            mode_l, mode_n;
  logic [31:0]     duty_n;
  logic            tc, step;

  assign state = st;
  assign tc    = (st != IDLE) && (presc == PRE_TC);
  // A terminal count coinciding with a wrap is consumed directly, never queued.
  assign step  = period_wrap && (pending || tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_comb begin
    st_n = st;
    if (st != IDLE && !enable) begin
      st_n = IDLE;
    end else begin
      case (st)
        IDLE:    if (enable) st_n = RISE;
        RISE:    if (step && mode_l && duty_cycle >= DUTY_MAX - 32'd1) st_n = HOLD_HI;
        HOLD_HI: if (step && hold == HOLD_END)
                   st_n = (DUTY_MAX == 32'd1) ? HOLD_LO : FALL;
        FALL:    if (step && duty_cycle == 32'd1) st_n = HOLD_LO;
        HOLD_LO: if (step && hold == HOLD_END) st_n = RISE;
        default: st_n = IDLE;
      endcase
    end
  end

  always_comb begin
    duty_n    = duty_cycle;
    hold_n    = hold;
    mode_n    = mode_l;
    presc_n   = tc ? '0 : presc + 1'b1;
    pending_n = step ? 1'b0 : (tc ? 1'b1 : pending);
    if (st == IDLE) begin
      presc_n   = '0;
      pending_n = 1'b0;
      hold_n    = '0;
      duty_n    = '0;
      if (enable) mode_n = mode;
    end else if (!enable) begin
      presc_n   = '0;
      pending_n = 1'b0;
      hold_n    = '0;
      duty_n    = '0;
    end else if (step) begin
      case (st)
        RISE: begin
          if (duty_cycle < DUTY_MAX) begin
            duty_n = duty_cycle + 32'd1;
            if (mode_l && duty_cycle == DUTY_MAX - 32'd1) hold_n = '0;
          end else if (!mode_l) begin
            duty_n = '0;
            mode_n = mode;
          end else begin
            hold_n = '0;
          end
        end
        HOLD_HI: begin
          if (hold < HOLD_END) begin
            hold_n = hold + 1'b1;
          end else begin
            hold_n = '0;
            duty_n = DUTY_MAX - 32'd1;
          end
        end
        FALL: begin
          if (duty_cycle != 32'd0) duty_n = duty_cycle - 32'd1;
          if (duty_cycle == 32'd1) hold_n = '0;
        end
        HOLD_LO: begin
          if (hold < HOLD_END) begin
            hold_n = hold + 1'b1;
          end else begin
            hold_n = '0;
            duty_n = 32'd1;
            mode_n = mode;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cycle  <= '0;
      duty_update <= 1'b0;
      presc       <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      mode_l      <= 1'b0;
    end else begin
      duty_cycle  <= duty_n;
      duty_update <= (duty_n != duty_cycle);
      presc       <= presc_n;
      hold        <= hold_n;
      pending     <= pending_n;
      mode_l      <= mode_n;
    end
  end

endmodule

// File: tb/tb_breath_ramp_gen.sv
// Directed bench for breath_ramp_gen with STEP_TICKS=4, DUTY_MAX=5, HOLD_STEPS=2.
module tb_breath_ramp_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        period_wrap = 1'b0;
  logic [31:0] duty_cycle;
  logic        duty_update;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  logic found;

  breath_ramp_gen #(.STEP_TICKS(4), .DUTY_MAX(32'd5), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .period_wrap(period_wrap), .duty_cycle(duty_cycle),
    .duty_update(duty_update), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n cycles of constant duty/state; update pulse expected only in the first one
  task automatic seg(input string tag, input int val, input int st, input int n, input bit first_upd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".duty"}, duty_cycle, val);
      chk({tag, ".state"}, {29'd0, state}, st);
      chk({tag, ".upd"}, {31'd0, duty_update}, (i == 0) ? first_upd : 0);
    end
  endtask

  task automatic do_reset();
    enable = 1'b0; period_wrap = 1'b0; mode = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values
    @(negedge clk);
    chk("rst.duty", duty_cycle, 0);
    chk("rst.state", {29'd0, state}, 0);
    chk("rst.upd", {31'd0, duty_update}, 0);

    // triangle, wrap every cycle
    do_reset();
    enable = 1'b1; mode = 1'b1; period_wrap = 1'b1;
    seg("tri0", 0, 1, 4, 0);
    for (int v = 1; v <= 4; v++) seg("tri_up", v, 1, 4, 1);
    seg("tri_pk", 5, 2, 12, 1);
    for (int v = 4; v >= 1; v--) seg("tri_dn", v, 3, 4, 1);
    seg("tri_lo", 0, 4, 12, 1);
    seg("tri_re", 1, 1, 4, 1);

    // sawtooth; mode raised mid-ramp must not act until the wrap sample point
    do_reset();
    enable = 1'b1; mode = 1'b0; period_wrap = 1'b1;
    seg("saw0", 0, 1, 4, 0);
    seg("saw", 1, 1, 4, 1);
    seg("saw", 2, 1, 4, 1);
    mode = 1'b1;
    for (int v = 3; v <= 5; v++) seg("saw", v, 1, 4, 1);
    seg("saw_wrap", 0, 1, 4, 1);
    seg("saw_wrap", 1, 1, 4, 1);

    // period_wrap every 10 cycles: one step per wrap, nothing skipped
    do_reset();
    enable = 1'b1; mode = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      period_wrap = (n % 10 == 0);
      @(negedge clk);
      chk("slow.duty", duty_cycle, n / 10);
      chk("slow.upd", {31'd0, duty_update}, (n % 10 == 0) ? 1 : 0);
    end

    // terminal count coinciding with wrap, then pending must be clear
    do_reset();
    enable = 1'b1; mode = 1'b0; period_wrap = 1'b0;
    seg("tc0", 0, 1, 4, 0);
    period_wrap = 1'b1; @(negedge clk);
    chk("tc.step", duty_cycle, 1);
    chk("tc.upd", {31'd0, duty_update}, 1);
    period_wrap = 1'b0; @(negedge clk);
    period_wrap = 1'b1; @(negedge clk);
    chk("tc.nopend", duty_cycle, 1);
    period_wrap = 1'b0; @(negedge clk);
    period_wrap = 1'b1; @(negedge clk);
    chk("tc.next", duty_cycle, 2);

    // enable dropped in FALL at duty 3
    do_reset();
    enable = 1'b1; mode = 1'b1; period_wrap = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd3 && duty_cycle == 32'd3) found = 1'b1;
    end
    chk("dis.reach", {31'd0, found}, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("dis.duty", duty_cycle, 0);
    chk("dis.state", {29'd0, state}, 0);
    chk("dis.upd", {31'd0, duty_update}, 1);
    @(negedge clk);
    chk("dis.upd2", {31'd0, duty_update}, 0);
    enable = 1'b1;
    seg("reen0", 0, 1, 4, 0);
    seg("reen1", 1, 1, 1, 1);

    // asynchronous reset in HOLD_HI, released with enable held high
    do_reset();
    enable = 1'b1; mode = 1'b1; period_wrap = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd2) found = 1'b1;
    end
    chk("ares.reach", {31'd0, found}, 1);
    chk("ares.pre", duty_cycle, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("ares.duty", duty_cycle, 0);
    chk("ares.state", {29'd0, state}, 0);
    chk("ares.upd", {31'd0, duty_update}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ares.rise", {29'd0, state}, 1);
    chk("ares.rduty", duty_cycle, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/breath_ramp_gen.md
BREATH_RAMP_GEN -- requirements
Module: breath_ramp_gen

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 125000, giving clk cycles per ramp step (5 ms at 25 MHz); legal range >=1.
REQ-002 SHALL have parameter DUTY_MAX, default 100, giving the peak duty value (equal to the downstream PWM period); legal range 1..2^32-1.
REQ-003 SHALL have parameter HOLD_STEPS, default 20, giving the extra steps held at peak and at trough in triangle mode; legal range >=0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: run request; 0 forces IDLE.
REQ-007 SHALL have port mode, input, 1 bit: 0 = sawtooth, 1 = triangle.
REQ-008 SHALL have port period_wrap, input, 1 bit: one-cycle pulse from the PWM stage marking its period boundary.
REQ-009 SHALL have port duty_cycle, output, 32 bits: registered duty value feeding the PWM duty_cycle input.
REQ-010 SHALL have port duty_update, output, 1 bit: registered one-cycle pulse, high in the first cycle duty_cycle shows a new value.
REQ-011 SHALL have port state, output, 3 bits: FSM state, encoded IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

Function
REQ-012 Prescaler SHALL count 0..STEP_TICKS-1 while state!=IDLE, wrap to 0 at terminal count, and set step_pending at that wrap.
REQ-013 A step SHALL be consumed only in a cycle with period_wrap=1 and (step_pending=1 or prescaler at terminal count that cycle); consuming clears step_pending.
REQ-014 Steps SHALL NOT accumulate: a terminal count while step_pending=1 leaves exactly one step pending.
REQ-015 IDLE with enable=1 SHALL move to RISE on the next edge; duty stays 0, prescaler starts at 0, mode is sampled and latched.
REQ-016 RISE step SHALL increment duty; on the step taking duty from DUTY_MAX-1 to DUTY_MAX, triangle mode SHALL enter HOLD_HI with hold_cnt=0.
REQ-017 RISE step in sawtooth mode with duty==DUTY_MAX SHALL set duty to 0, stay in RISE, and re-sample mode.
REQ-018 HOLD_HI step SHALL leave duty unchanged and increment hold_cnt while hold_cnt<HOLD_STEPS; at hold_cnt==HOLD_STEPS it SHALL enter FALL and set duty to DUTY_MAX-1.
REQ-019 FALL step SHALL decrement duty; the step reaching 0 SHALL enter HOLD_LO with hold_cnt=0.
REQ-020 HOLD_LO SHALL behave as HOLD_HI; on exit it SHALL re-sample mode, enter RISE, and set duty to 1.
REQ-021 Each extreme SHALL therefore be held for HOLD_STEPS+1 step intervals; with DUTY_MAX=1, FALL is skipped and HOLD_HI exits directly through duty 0 into HOLD_LO.
REQ-022 duty_cycle SHALL stay within 0..DUTY_MAX at all times, with no wrap-around in either direction.
REQ-023 duty_update SHALL pulse exactly when duty_cycle changes value, and never on hold steps.
REQ-024 enable=0 in any non-IDLE state SHALL, on the next edge and without waiting for period_wrap, set state IDLE and duty 0, and clear prescaler, hold_cnt and step_pending; duty_update SHALL pulse if duty was nonzero.
REQ-025 mode changes SHALL take effect only at the sample points in REQ-015, REQ-017 and REQ-020.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force duty_cycle=0, duty_update=0, state=IDLE, and clear prescaler, hold_cnt, step_pending and the latched mode.
REQ-027 The first rising edge after rst_n deasserts SHALL evaluate normally; an enable=1 held through reset moves the FSM to RISE on that edge.

Verification (STEP_TICKS=4, DUTY_MAX=5, HOLD_STEPS=2 unless stated)
REQ-028 Bench SHALL check: period_wrap=1, mode=1, enable=1 -> duty 0,1,2,3,4,5 changing every 4 cycles, 5 held 12 cycles, then 4,3,2,1,0, 0 held 12 cycles, then 1.
REQ-029 Bench SHALL check: period_wrap=1, mode=0 -> duty 0..5, then 0,1, with one duty_update pulse per step and no holds.
REQ-030 Bench SHALL check: period_wrap pulsing every 10 cycles -> duty changes only on wrap cycles, at most one step per wrap, no values skipped.
REQ-031 Bench SHALL check: enable dropped in FALL at duty 3 -> next edge gives duty 0, state IDLE and one duty_update pulse; re-enable restarts RISE from 0.
REQ-032 Bench SHALL check: rst_n asserted between clock edges in HOLD_HI -> duty_cycle 0 and state 0 before the next edge.
REQ-033 Bench SHALL check: terminal count coinciding with period_wrap -> step taken in that same cycle and step_pending left clear.
